// File: rtl/dm_bus_pkg.sv
`default_nettype none
// dm_bus_pkg: lock FSM encoding and byte-lane legality table shared by the data-memory arbiter.
package dm_bus_pkg;

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;

  localparam logic [3:0] BE_READ  = 4'b0000;
  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;

  // True when the enabled lanes form a naturally aligned access at this byte offset.
  function automatic logic lane_ok(input logic [3:0] be, input logic [1:0] off);
    logic ok;
    case (be)
      BE_READ:                      ok = 1'b1;
      BE_WORD, BE_HALF0, BE_BYTE0:  ok = (off == 2'd0);
      BE_BYTE1:                     ok = (off == 2'd1);
      BE_HALF1, BE_BYTE2:           ok = (off == 2'd2);
      BE_BYTE3:                     ok = (off == 2'd3);
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_access_check.sv
`default_nettype none
// dm_access_check: combinational legality check of one requester's address and byte enables.
module dm_access_check
  import dm_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  output logic        illegal
);

  logic in_range;

  assign in_range = (addr >> 2) < 32'(DEPTH_WORDS);
  assign illegal  = !lane_ok(byteen, addr[1:0]) || !in_range;

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// dm_arbiter: two-port round-robin data-memory arbiter with lock support and registered responses.
module dm_arbiter
  import dm_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  byteen0,
  input  logic [3:0]  byteen1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata
);

  lock_state_e state, state_next;
  logic        last_gnt;
  logic        illegal0, illegal1;
  logic        elig0, elig1;
  logic        sel_illegal, sel_lock;

  dm_access_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_check0 (
    .addr    (addr0),
    .byteen  (byteen0),
    .illegal (illegal0)
  );

  dm_access_check #(.DEPTH_WORDS(DEPTH_WORDS)) u_check1 (
    .addr    (addr1),
    .byteen  (byteen1),
    .illegal (illegal1)
  );

  // A locked state shuts out the other port even when the holder is idle.
  always_comb begin
    elig0 = req0 && !reset && (state != LOCK1);
    elig1 = req1 && !reset && (state != LOCK0);
    gnt0  = elig0 && (!elig1 || last_gnt);
    gnt1  = elig1 && (!elig0 || !last_gnt);
  end

  always_comb begin
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_byteen  = 4'd0;
    sel_illegal = 1'b0;
    sel_lock    = 1'b0;
    if (gnt0) begin
      mem_addr    = {addr0[31:2], 2'b00};
      mem_wdata   = wdata0;
      mem_byteen  = illegal0 ? 4'd0 : byteen0;
      sel_illegal = illegal0;
      sel_lock    = lock0;
    end else if (gnt1) begin
      mem_addr    = {addr1[31:2], 2'b00};
      mem_wdata   = wdata1;
      mem_byteen  = illegal1 ? 4'd0 : byteen1;
      sel_illegal = illegal1;
      sel_lock    = lock1;
    end
  end

  // An erroring access that asks for the lock leaves the state untouched.
  always_comb begin
    state_next = state;
    if (gnt0 || gnt1) begin
      if (!sel_lock) begin
        state_next = OPEN;
      end else if (!sel_illegal) begin
        state_next = gnt0 ? LOCK0 : LOCK1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= OPEN;
      last_gnt <= 1'b1;
    end else begin
      state <= state_next;
      if (gnt0) begin
        last_gnt <= 1'b0;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata0  <= 32'd0;
      rdata1  <= 32'd0;
    end else begin
      rvalid0 <= gnt0;
      rvalid1 <= gnt1;
      err0    <= gnt0 && illegal0;
      err1    <= gnt1 && illegal1;
      rdata0  <= (gnt0 && !illegal0 && byteen0 == BE_READ) ? mem_rdata : 32'd0;
      rdata1  <= (gnt1 && !illegal1 && byteen1 == BE_READ) ? mem_rdata : 32'd0;
    end
  end

endmodule
`default_nettype wire
